// File: rtl/io_pinmux_pkg.sv
// Register offsets, lock key and SEL-word geometry helpers shared by the io_pinmux files.
package io_pinmux_pkg;

  localparam logic [7:0] CTRL_OFF = 8'h00;
  localparam logic [7:0] STAT_OFF = 8'h04;
  localparam logic [7:0] SEL_BASE = 8'h10;
  localparam logic [7:0] LOCK_KEY = 8'hA5;

  // Number of SW-bit pad fields that fit in one 32-bit SEL word.
  function automatic int pins_per_word(input int sw);
    return 32 / sw;
  endfunction

  function automatic int sel_words(input int npins, input int sw);
    return (npins + pins_per_word(sw) - 1) / pins_per_word(sw);
  endfunction

endpackage

// File: rtl/io_pinmux_sync.sv
// Multi-stage input synchroniser for the pad inputs; every stage clears on reset.
module io_pinmux_sync
  import io_pinmux_pkg::*;
#(
  parameter int NPINS       = 38,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [NPINS-1:0] i_d,
  output logic [NPINS-1:0] o_q
);

  logic [NPINS-1:0] r_stage [SYNC_STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/io_pinmux.sv
// APB-programmable pad multiplexer: per-pad function select, global output enable,
// tri-state guard after reselection and a sticky configuration lock.
module io_pinmux
  import io_pinmux_pkg::*;
#(
  parameter int               NPINS       = 38,
  parameter int               NFUNC       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               GUARD       = 4,
  parameter logic [NFUNC-1:0] IN_IDLE     = {{(NFUNC-1){1'b1}}, 1'b0}
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [7:0]             PADDR,
  input  logic [31:0]            PWDATA,
  output logic [31:0]            PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  input  logic [NFUNC*NPINS-1:0] func_out,
  input  logic [NFUNC*NPINS-1:0] func_oe,
  output logic [NFUNC*NPINS-1:0] func_in,
  input  logic [NPINS-1:0]       io_in,
  output logic [NPINS-1:0]       io_out,
  output logic [NPINS-1:0]       io_oeb
);

  localparam int              SW       = $clog2(NFUNC);
  localparam int              PPW      = pins_per_word(SW);
  localparam int              NWORDS   = sel_words(NPINS, SW);
  localparam int              FLATW    = NWORDS * 32;
  localparam int              GW       = $clog2(GUARD + 1);
  localparam logic [7:0]      SEL_END  = SEL_BASE + 8'(4 * NWORDS);
  localparam logic [GW-1:0]   GUARD_LD = GW'(GUARD);

  logic [NPINS-1:0][SW-1:0] r_sel;
  logic                     r_out_en;
  logic                     r_locked;
  logic [GW-1:0]            r_gcnt;
  logic [NPINS-1:0]         r_pend;
  logic [NPINS-1:0]         r_io_out;
  logic [NPINS-1:0]         r_io_oeb;

  logic [NPINS-1:0][SW-1:0] w_sel_next;
  logic [NPINS-1:0]         w_chg;
  logic [NPINS-1:0]         w_out_mux;
  logic [NPINS-1:0]         w_oe_mux;
  logic [NPINS-1:0]         w_sync;
  logic [NPINS-1:0]         w_pend_next;
  logic [GW-1:0]            w_gcnt_next;
  logic                     w_any_chg;
  logic                     w_out_en_next;
  logic                     w_locked_next;
  logic                     w_access;
  logic                     w_wr;
  logic                     w_ctrl_wr;
  logic                     w_sel_wr;
  logic                     w_hit_ctrl;
  logic                     w_hit_stat;
  logic                     w_hit_sel;
  logic [7:0]               w_sel_off;
  logic [5:0]               w_word;
  logic [FLATW-1:0]         w_sel_flat;
  logic [31:0]              w_rdata;

  // APB decode; accesses always complete with zero wait states
  assign w_access   = PSEL & PENABLE;
  assign w_wr       = w_access & PWRITE;
  assign w_sel_off  = PADDR - SEL_BASE;
  assign w_word     = w_sel_off[7:2];
  assign w_hit_ctrl = (PADDR == CTRL_OFF);
  assign w_hit_stat = (PADDR == STAT_OFF);
  assign w_hit_sel  = (PADDR >= SEL_BASE) && (PADDR < SEL_END) && (w_sel_off[1:0] == 2'b00);
  assign w_ctrl_wr  = w_wr & w_hit_ctrl;
  assign w_sel_wr   = w_wr & w_hit_sel & ~r_locked;

  assign PREADY  = 1'b1;
  assign PSLVERR = w_access & (~(w_hit_ctrl | w_hit_stat | w_hit_sel) |
                               (PWRITE & r_locked & (w_hit_ctrl | w_hit_sel)));

  for (genvar gi = 0; gi < NPINS; gi++) begin : g_pad
    localparam int WI = gi / PPW;
    localparam int FI = gi % PPW;
    logic [NFUNC-1:0] w_fo;
    logic [NFUNC-1:0] w_foe;

    for (genvar gj = 0; gj < NFUNC; gj++) begin : g_fn
      assign w_fo[gj]               = func_out[gj*NPINS + gi];
      assign w_foe[gj]              = func_oe[gj*NPINS + gi];
      assign func_in[gj*NPINS + gi] = (r_sel[gi] == SW'(gj)) ? w_sync[gi] : IN_IDLE[gj];
    end

    assign w_sel_next[gi] = (w_sel_wr && (w_word == 6'(WI))) ? PWDATA[FI*SW +: SW] : r_sel[gi];
    assign w_chg[gi]      = (w_sel_next[gi] != r_sel[gi]);
    // The new selection drives the mux on the same edge the write lands
    assign w_out_mux[gi]  = w_fo[w_sel_next[gi]];
    assign w_oe_mux[gi]   = w_foe[w_sel_next[gi]];
  end

  assign w_any_chg = |w_chg;

  // pend is held one cycle past gcnt reaching zero so the pad stays
  // tri-stated through the final guard cycle.
  always_comb begin
    w_gcnt_next = r_gcnt;
    w_pend_next = r_pend;
    if (w_any_chg) begin
      w_gcnt_next = GUARD_LD;
      w_pend_next = r_pend | w_chg;
    end else if (r_gcnt != '0) begin
      w_gcnt_next = r_gcnt - 1'b1;
    end else begin
      w_pend_next = '0;
    end
  end

  assign w_out_en_next = (w_ctrl_wr & ~r_locked) ? PWDATA[0] : r_out_en;
  assign w_locked_next = r_locked | (w_ctrl_wr & (PWDATA[15:8] == LOCK_KEY));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sel    <= '0;
      r_out_en <= 1'b0;
      r_locked <= 1'b0;
      r_gcnt   <= '0;
      r_pend   <= '0;
      r_io_out <= '0;
      r_io_oeb <= '1;
    end else begin
      r_sel    <= w_sel_next;
      r_out_en <= w_out_en_next;
      r_locked <= w_locked_next;
      r_gcnt   <= w_gcnt_next;
      r_pend   <= w_pend_next;
      r_io_out <= w_out_mux;
      r_io_oeb <= ~(w_oe_mux & {NPINS{w_out_en_next}} & ~w_pend_next);
    end
  end

  assign io_out = r_io_out;
  assign io_oeb = r_io_oeb;

  io_pinmux_sync #(
    .NPINS       (NPINS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (HCLK),
    .i_rst_n (HRESETn),
    .i_d     (io_in),
    .o_q     (w_sync)
  );

  // Fields of non-existent pads in the last SEL word read back as zero
  assign w_sel_flat = FLATW'(r_sel);

  always_comb begin
    w_rdata = '0;
    if (w_hit_ctrl) begin
      w_rdata[0] = r_out_en;
    end else if (w_hit_stat) begin
      w_rdata[1:0] = {r_locked, (r_gcnt != '0)};
    end else if (w_hit_sel) begin
      w_rdata = w_sel_flat[w_word*32 +: 32];
    end
  end

  assign PRDATA = (w_access & ~PWRITE) ? w_rdata : 32'h0;

endmodule

// File: tb/tb_io_pinmux.sv
// Directed bench for io_pinmux: reset, output path, guard timing, lock, decode errors, async reset.
module tb_io_pinmux;

  localparam int NPINS = 38;
  localparam int NFUNC = 4;
  localparam int NB    = NPINS * NFUNC;

  localparam logic [NPINS-1:0] ALL1  = '1;
  localparam logic [NPINS-1:0] PAT   = 38'h1A_A5A5_A5A5;
  localparam logic [NPINS-1:0] BIT21 = 38'h00_0020_0000;
  localparam logic [NPINS-1:0] BIT5  = 38'h00_0000_0020;

  localparam logic [7:0] A_CTRL = 8'h00;
  localparam logic [7:0] A_STAT = 8'h04;
  localparam logic [7:0] A_SEL0 = 8'h10;
  localparam logic [7:0] A_SEL1 = 8'h14;
  localparam logic [7:0] A_SEL2 = 8'h18;

  logic          HCLK    = 1'b0;
  logic          HRESETn = 1'b0;
  logic          PSEL    = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE  = 1'b0;
  logic [7:0]    PADDR   = 8'h00;
  logic [31:0]   PWDATA  = 32'h0;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [NB-1:0] func_out = '0;
  logic [NB-1:0] func_oe  = '0;
  logic [NB-1:0] func_in;
  logic [NPINS-1:0] io_in = '0;
  logic [NPINS-1:0] io_out;
  logic [NPINS-1:0] io_oeb;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 HCLK = ~HCLK;

  io_pinmux #(
    .NPINS       (NPINS),
    .NFUNC       (NFUNC),
    .SYNC_STAGES (2),
    .GUARD       (4),
    .IN_IDLE     (4'b1110)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .func_out (func_out),
    .func_oe  (func_oe),
    .func_in  (func_in),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb)
  );

  // Called at a negedge; returns at the negedge of the cycle after the access edge.
  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    $display("apb wr addr=%02h data=%08h slverr=%0b", addr, data, err);
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [31:0] data, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1 begin data = PRDATA; err = PSLVERR; end
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    $display("apb rd addr=%02h data=%08h slverr=%0b", addr, data, err);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        err;
    HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    n_cmp++; if (io_oeb !== ALL1) begin n_mis++; $display("FAIL reset_oeb: got %h want %h", io_oeb, ALL1); end
    n_cmp++; if (io_out !== '0) begin n_mis++; $display("FAIL reset_out: got %h want 0", io_out); end
    n_cmp++; if (PRDATA !== 32'h0 || PSLVERR !== 1'b0 || PREADY !== 1'b1) begin
      n_mis++; $display("FAIL reset_apb: prdata=%h slverr=%b pready=%b want 0/0/1", PRDATA, PSLVERR, PREADY);
    end
    io_in   = PAT;
    HRESETn = 1'b1;
    @(negedge HCLK);
    n_cmp++; if (func_in[NPINS-1:0] !== '0) begin n_mis++; $display("FAIL sync_stage1: got %h want 0", func_in[NPINS-1:0]); end
    n_cmp++; if (func_in[NB-1:NPINS] !== '1) begin n_mis++; $display("FAIL idle_slots: got %h want all ones", func_in[NB-1:NPINS]); end
    @(negedge HCLK);
    n_cmp++; if (func_in[NPINS-1:0] !== PAT) begin n_mis++; $display("FAIL sync_stage2: got %h want %h", func_in[NPINS-1:0], PAT); end
    n_cmp++; if (io_oeb !== ALL1 || io_out !== '0) begin n_mis++; $display("FAIL idle_pads: oeb=%h out=%h want all1/0", io_oeb, io_out); end
    apb_read(A_STAT, rd, err);
    n_cmp++; if (rd !== 32'h0 || err !== 1'b0) begin n_mis++; $display("FAIL reset_status: got %h/%b want 0/0", rd, err); end
  endtask

  task automatic test_output();
    logic [31:0] rd;
    logic        err;
    logic        vals [5];
    logic        prev;
    vals = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    func_oe[21] = 1'b1;
    apb_write(A_CTRL, 32'h1, err);
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL ctrl_wr_err: got %b want 0", err); end
    n_cmp++; if (io_oeb !== (ALL1 ^ BIT21)) begin n_mis++; $display("FAIL out_en_oeb: got %h want %h", io_oeb, ALL1 ^ BIT21); end
    prev = 1'b0;
    for (int i = 0; i < 5; i++) begin
      func_out[21] = vals[i];
      #1;
      n_cmp++; if (io_out[21] !== prev) begin n_mis++; $display("FAIL out_latency[%0d]: got %b want %b", i, io_out[21], prev); end
      @(negedge HCLK);
      n_cmp++; if (io_out[21] !== vals[i]) begin n_mis++; $display("FAIL out_follow[%0d]: got %b want %b", i, io_out[21], vals[i]); end
      prev = vals[i];
    end
    apb_read(A_CTRL, rd, err);
    n_cmp++; if (rd !== 32'h1 || err !== 1'b0) begin n_mis++; $display("FAIL ctrl_rd: got %h/%b want 1/0", rd, err); end
  endtask

  task automatic test_guard();
    logic [31:0] rd;
    logic        err;
    func_oe[NPINS+21]  = 1'b1;
    func_out[NPINS+21] = 1'b1;
    func_out[21]       = 1'b0;
    apb_write(A_SEL1, 32'h0000_0400, err);
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL sel1_wr_err: got %b want 0", err); end
    n_cmp++; if (io_oeb !== ALL1) begin n_mis++; $display("FAIL guard_t1: got %h want %h", io_oeb, ALL1); end
    for (int k = 2; k <= 5; k++) begin
      @(negedge HCLK);
      n_cmp++; if (io_oeb[21] !== 1'b1) begin n_mis++; $display("FAIL guard_t%0d: got %b want 1", k, io_oeb[21]); end
    end
    @(negedge HCLK);
    n_cmp++; if (io_oeb !== (ALL1 ^ BIT21)) begin n_mis++; $display("FAIL guard_release: got %h want %h", io_oeb, ALL1 ^ BIT21); end
    n_cmp++; if (io_out[21] !== 1'b1) begin n_mis++; $display("FAIL func1_out_hi: got %b want 1", io_out[21]); end
    func_out[NPINS+21] = 1'b0;
    @(negedge HCLK);
    n_cmp++; if (io_out[21] !== 1'b0) begin n_mis++; $display("FAIL func1_out_lo: got %b want 0", io_out[21]); end
    n_cmp++; if (func_in[21] !== 1'b0 || func_in[NPINS+21] !== 1'b1 || func_in[2*NPINS+21] !== 1'b1) begin
      n_mis++; $display("FAIL func_in_route: slot0=%b slot1=%b slot2=%b want 0/1/1",
                        func_in[21], func_in[NPINS+21], func_in[2*NPINS+21]);
    end
    apb_read(A_SEL1, rd, err);
    n_cmp++; if (rd !== 32'h0000_0400 || err !== 1'b0) begin n_mis++; $display("FAIL sel1_rd: got %h/%b want 00000400/0", rd, err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        err;
    apb_write(A_SEL1, 32'h0000_0000, err);
    n_cmp++; if (io_oeb[21] !== 1'b1) begin n_mis++; $display("FAIL b2b_first: got %b want 1", io_oeb[21]); end
    @(negedge HCLK);
    apb_write(A_SEL1, 32'h0000_0100, err);
    for (int k = 1; k <= 5; k++) begin
      n_cmp++; if (io_oeb[21] !== 1'b1) begin n_mis++; $display("FAIL b2b_ext_t%0d: got %b want 1", k, io_oeb[21]); end
      @(negedge HCLK);
    end
    n_cmp++; if (io_oeb[21] !== 1'b0) begin n_mis++; $display("FAIL b2b_release: got %b want 0", io_oeb[21]); end

    apb_write(A_SEL1, 32'h0000_0400, err);
    apb_read(A_STAT, rd, err);
    n_cmp++; if (rd !== 32'h1) begin n_mis++; $display("FAIL busy_a: got %h want 1", rd); end
    apb_write(A_SEL1, 32'h0000_0500, err);
    apb_read(A_STAT, rd, err);
    n_cmp++; if (rd !== 32'h1) begin n_mis++; $display("FAIL busy_b2: got %h want 1", rd); end
    apb_read(A_STAT, rd, err);
    n_cmp++; if (rd !== 32'h1) begin n_mis++; $display("FAIL busy_b4: got %h want 1", rd); end
    apb_read(A_STAT, rd, err);
    n_cmp++; if (rd !== 32'h0) begin n_mis++; $display("FAIL busy_end: got %h want 0", rd); end
    apb_write(A_SEL1, 32'h0000_0500, err);
    apb_read(A_STAT, rd, err);
    n_cmp++; if (rd !== 32'h0) begin n_mis++; $display("FAIL nochange_idle: got %h want 0", rd); end
  endtask

  task automatic test_sel_readback();
    logic [31:0] rd;
    logic        err;
    apb_write(A_SEL2, 32'hFFFF_FFFF, err);
    apb_read(A_SEL2, rd, err);
    n_cmp++; if (rd !== 32'h0000_0FFF || err !== 1'b0) begin n_mis++; $display("FAIL sel2_rd: got %h/%b want 00000fff/0", rd, err); end
    apb_write(A_SEL2, 32'h0000_0000, err);
    apb_read(A_SEL0, rd, err);
    n_cmp++; if (rd !== 32'h0) begin n_mis++; $display("FAIL sel0_rd: got %h want 0", rd); end
    repeat (8) @(negedge HCLK);
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    logic        err;
    apb_read(8'h40, rd, err);
    n_cmp++; if (rd !== 32'h0 || err !== 1'b1) begin n_mis++; $display("FAIL unmap_40: got %h/%b want 0/1", rd, err); end
    apb_read(8'h08, rd, err);
    n_cmp++; if (rd !== 32'h0 || err !== 1'b1) begin n_mis++; $display("FAIL unmap_08: got %h/%b want 0/1", rd, err); end
    apb_read(8'h11, rd, err);
    n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL unmap_11: got %b want 1", err); end
    apb_write(8'h1C, 32'h1234_5678, err);
    n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL unmap_1c_wr: got %b want 1", err); end
  endtask

  task automatic test_lock();
    logic [31:0] rd;
    logic        err;
    apb_write(A_CTRL, 32'h0, err);
    apb_write(A_CTRL, 32'h0000_A501, err);
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL lock_wr_err: got %b want 0", err); end
    apb_read(A_CTRL, rd, err);
    n_cmp++; if (rd !== 32'h1) begin n_mis++; $display("FAIL lock_outen: got %h want 1", rd); end
    apb_read(A_STAT, rd, err);
    n_cmp++; if (rd !== 32'h2) begin n_mis++; $display("FAIL lock_status: got %h want 2", rd); end
    apb_write(A_SEL0, 32'h0000_FFFF, err);
    n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL locked_sel_err: got %b want 1", err); end
    apb_read(A_SEL0, rd, err);
    n_cmp++; if (rd !== 32'h0 || err !== 1'b0) begin n_mis++; $display("FAIL locked_sel_rd: got %h/%b want 0/0", rd, err); end
    apb_read(A_STAT, rd, err);
    n_cmp++; if (rd !== 32'h2) begin n_mis++; $display("FAIL locked_status2: got %h want 2", rd); end
    apb_write(A_CTRL, 32'h0, err);
    n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL locked_ctrl_err: got %b want 1", err); end
    apb_read(A_CTRL, rd, err);
    n_cmp++; if (rd !== 32'h1) begin n_mis++; $display("FAIL locked_ctrl_rd: got %h want 1", rd); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    logic        err;
    func_out[NPINS+21] = 1'b1;
    @(negedge HCLK);
    n_cmp++; if (io_out[21] !== 1'b1 || io_oeb[21] !== 1'b0) begin
      n_mis++; $display("FAIL prereset_pad21: out=%b oeb=%b want 1/0", io_out[21], io_oeb[21]);
    end
    #2 HRESETn = 1'b0;
    #1;
    n_cmp++; if (io_oeb !== ALL1 || io_out !== '0) begin n_mis++; $display("FAIL async_rst: oeb=%h out=%h want all1/0", io_oeb, io_out); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    apb_read(A_STAT, rd, err);
    n_cmp++; if (rd !== 32'h0) begin n_mis++; $display("FAIL rst_unlock: got %h want 0", rd); end
    apb_read(A_SEL1, rd, err);
    n_cmp++; if (rd !== 32'h0) begin n_mis++; $display("FAIL rst_sel1: got %h want 0", rd); end

    func_oe[5] = 1'b1;
    apb_write(A_CTRL, 32'h1, err);
    n_cmp++; if (err !== 1'b0 || io_oeb[5] !== 1'b0) begin n_mis++; $display("FAIL relock_ctrl: err=%b oeb5=%b want 0/0", err, io_oeb[5]); end
    apb_write(A_SEL1, 32'h0000_0400, err);
    @(negedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    n_cmp++; if (io_oeb !== ALL1 || io_out !== '0) begin n_mis++; $display("FAIL rst_mid_guard: oeb=%h out=%h want all1/0", io_oeb, io_out); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    apb_read(A_STAT, rd, err);
    n_cmp++; if (rd !== 32'h0) begin n_mis++; $display("FAIL rst_guard_status: got %h want 0", rd); end
    n_cmp++; if (io_oeb !== ALL1) begin n_mis++; $display("FAIL rst_outen_cleared: got %h want %h", io_oeb, ALL1); end
  endtask

  initial begin
    test_reset();
    test_output();
    test_guard();
    test_back_to_back();
    test_sel_readback();
    test_unmapped();
    test_lock();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
